// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the IF/LS memory port arbiter.
// Holds the exception width, memory width codes and the arbiter state encodings.
package mem_port_arbiter_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_GRANT_IF = 2'd1;
    localparam logic [1:0] ARB_GRANT_LS = 2'd2;

    typedef struct packed {
        logic gnt_if;
        logic gnt_ls;
    } arb_grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic        is_read;
        logic        access;
    } mem_req_t;

    // Map a one-hot grant onto the FSM state it leads to from IDLE.
    function automatic logic [1:0] grant_to_state(input arb_grant_t g);
        logic [1:0] s;
        s = ARB_IDLE;
        if (g.gnt_ls) begin
            s = ARB_GRANT_LS;
        end else if (g.gnt_if) begin
            s = ARB_GRANT_IF;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the memory port arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise LS beats IF.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       last_ls,
    output arb_grant_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, hand the port to whoever did not have it last time.
    always_comb begin
        grant = '0;
        if (if_req && ls_req) begin
            grant.gnt_if = last_ls;
            grant.gnt_ls = !last_ls;
        end else begin
            grant.gnt_if = if_req;
            grant.gnt_ls = ls_req;
        end
    end
`else
    logic unused_last_ls;
    assign unused_last_ls = last_ls;

    // The backend may be stalled on a pending load/store, so it always wins.
    always_comb begin
        grant        = '0;
        grant.gnt_ls = ls_req;
        grant.gnt_if = if_req && !ls_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and load/store (LS).
// Optional round-robin tie-break under MEM_ARB_ROUND_ROBIN_EN; default is fixed LS priority.
//
// Handshake: a requester holds access high until it sees a one-cycle accessOK;
// dropping access before accessOK cancels the request. Only the granted side
// ever sees accessOK/data/exception; the other side reads zeros.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,

    input  logic [31:0]              ifAddr_In,
    input  logic [31:0]              ifData_In,
    input  logic [1:0]               ifWidth_In,
    input  logic                     ifIsRead_In,
    input  logic                     ifAccess_In,
    output logic                     ifAccessOK_Out,
    output logic [31:0]              ifData_Out,
    output logic [EXCEPTION_LEN-1:0] ifException_Out,

    input  logic [31:0]              lsAddr_In,
    input  logic [31:0]              lsData_In,
    input  logic [1:0]               lsWidth_In,
    input  logic                     lsIsRead_In,
    input  logic                     lsAccess_In,
    output logic                     lsAccessOK_Out,
    output logic [31:0]              lsData_Out,
    output logic [EXCEPTION_LEN-1:0] lsException_Out,

    output logic [31:0]              memAddr_Out,
    output logic [31:0]              memData_Out,
    output logic [1:0]               memDataWidth_Out,
    output logic                     memIsRead_Out,
    output logic                     memAccess_Out,
    input  logic                     memAccessOK_In,
    input  logic [31:0]              memData_In,
    input  logic [EXCEPTION_LEN-1:0] memException_In,

    output logic                     grantIF_Out,
    output logic                     grantLS_Out,
    output logic [1:0]               state_dbg
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_ls;
    arb_grant_t pick_grant;

    mem_arb_pick u_pick (
        .if_req  (ifAccess_In),
        .ls_req  (lsAccess_In),
        .last_ls (last_ls),
        .grant   (pick_grant)
    );

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:     state_next = grant_to_state(pick_grant);
            ARB_GRANT_IF: if (memAccessOK_In || !ifAccess_In) state_next = ARB_IDLE;
            ARB_GRANT_LS: if (memAccessOK_In || !lsAccess_In) state_next = ARB_IDLE;
            default:      state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Resetting to LS means IF takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls <= 1'b1;
        end else if (state == ARB_IDLE && state_next != ARB_IDLE) begin
            last_ls <= (state_next == ARB_GRANT_LS);
        end
    end
`else
    assign last_ls = 1'b1;
`endif

    assign grantIF_Out = (state == ARB_GRANT_IF);
    assign grantLS_Out = (state == ARB_GRANT_LS);
    assign state_dbg   = state;

    // Request path: the granted side's signals pass through unaltered.
    mem_req_t if_req_bus;
    mem_req_t ls_req_bus;
    mem_req_t mem_req;

    assign if_req_bus = '{addr: ifAddr_In, data: ifData_In, width: ifWidth_In,
                          is_read: ifIsRead_In, access: ifAccess_In};
    assign ls_req_bus = '{addr: lsAddr_In, data: lsData_In, width: lsWidth_In,
                          is_read: lsIsRead_In, access: lsAccess_In};

    always_comb begin
        mem_req = '0;
        if (grantIF_Out) begin
            mem_req = if_req_bus;
        end else if (grantLS_Out) begin
            mem_req = ls_req_bus;
        end
    end

    assign memAddr_Out      = mem_req.addr;
    assign memData_Out      = mem_req.data;
    assign memDataWidth_Out = mem_req.width;
    assign memIsRead_Out    = mem_req.is_read;
    assign memAccess_Out    = mem_req.access;

    // Response path is blanked while rst is high so an in-flight OK is dropped.
    logic resp_if;
    logic resp_ls;

    assign resp_if = grantIF_Out && !rst;
    assign resp_ls = grantLS_Out && !rst;

    assign ifAccessOK_Out  = resp_if && memAccessOK_In;
    assign ifData_Out      = resp_if ? memData_In : 32'd0;
    assign ifException_Out = resp_if ? memException_In : '0;

    assign lsAccessOK_Out  = resp_ls && memAccessOK_In;
    assign lsData_Out      = resp_ls ? memData_In : 32'd0;
    assign lsException_Out = resp_ls ? memException_In : '0;

endmodule
